req_ack_timeout_ctrl: RTL and testbench

Requester-side handshake sequencer that converts a one-cycle start command into a req/ack transaction with a bounded wait. It drives req and waits a bounded number of cycles for a rising edge on ack. On timeout it drops req, retries up to a fixed count, then flags an error. It replaces open-ended req→ack waits with a deterministic controller whose bounds are checkable by assertions.

---
 rtl/req_ack_timeout_ctrl.sv | 124 ++++++++++++
 tb/tb_req_ack_timeout_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_timeout_ctrl.sv
// Requester-side req/ack sequencer: raises req per attempt, waits a bounded
// number of cycles for an ack rising edge, retries after a low gap, then flags err.
module req_ack_timeout_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GAP       = 2,
  parameter int unsigned CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          ack,
  output logic          req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] retry_cnt,
  output logic [CW-1:0] last_lat
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StWaitAck, StGap} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ack_q;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] retry_cnt_q, retry_cnt_d;
  logic [CW-1:0] last_lat_q, last_lat_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ack_rise;

  // A level already high before the attempt never counts; only a fresh edge does.
  assign ack_rise = ack & ~ack_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    retry_cnt_d = retry_cnt_q;
    last_lat_d  = last_lat_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d     = StWaitAck;
          wait_cnt_d  = '0;
          retry_cnt_d = '0;
        end
      end
      StWaitAck: begin
        if (abort) begin
          state_d = StIdle;
        end else if (ack_rise) begin
          state_d    = StIdle;
          done_d     = 1'b1;
          last_lat_d = wait_cnt_q;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          if (retry_cnt_q < CW'(MAX_RETRY)) begin
            state_d     = StGap;
            gap_cnt_d   = '0;
            retry_cnt_d = retry_cnt_q + 1'b1;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
        end else if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d    = StWaitAck;
          wait_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    req_d = (state_d == StWaitAck);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      retry_cnt_q <= '0;
      last_lat_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ack_q       <= ack;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      last_lat_q  <= last_lat_d;
    end
  end

  assign req       = req_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;
  assign retry_cnt = retry_cnt_q;
  assign last_lat  = last_lat_q;

endmodule

// File: tb/tb_req_ack_timeout_ctrl.sv
// Bench for req_ack_timeout_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a timeline-arithmetic model.
module tb_req_ack_timeout_ctrl;

  localparam int unsigned T   = 16;
  localparam int unsigned MR  = 3;
  localparam int unsigned G   = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned P   = T + G;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ack = 1'b0;
  logic          req, busy, done, err;
  logic [CW-1:0] retry_cnt, last_lat;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  req_ack_timeout_ctrl #(
    .TIMEOUT  (T),
    .MAX_RETRY(MR),
    .GAP      (G),
    .CW       (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ack      (ack),
    .req      (req),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .retry_cnt(retry_cnt),
    .last_lat (last_lat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction is a timeline from its accepting edge; attempt k and the
  // offset inside it follow from (edge - start_edge) by division by T+G.
  int   e = 0;
  int   m_t0 = 0;
  bit   m_active = 0;
  int   m_retry = 0;
  int   m_lat = 0;
  bit   m_ack_prev = 0;
  bit   exp_req = 0, exp_done = 0, exp_err = 0;

  always @(posedge clk) begin
    int d, k, o;
    bit rise;
    rise = ack && !m_ack_prev;
    m_ack_prev = ack;
    exp_done = 0;
    exp_err  = 0;
    if (rst) begin
      m_active = 0; m_retry = 0; m_lat = 0; m_ack_prev = 0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1; m_t0 = e; m_retry = 0;
      end
    end else begin
      d = e - m_t0 - 1;
      k = d / P;
      o = d % P;
      if (abort) begin
        m_active = 0;
      end else if (o < T) begin
        if (rise) begin
          exp_done = 1; m_lat = o; m_active = 0;
        end else if (o == T - 1) begin
          if (k < MR) m_retry = k + 1;
          else begin
            exp_err = 1; m_active = 0;
          end
        end
      end
    end
    exp_req = m_active && (((e - m_t0) % P) < T);
    e++;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req", {31'd0, req}, {31'd0, exp_req});
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("err", {31'd0, err}, {31'd0, exp_err});
      chk("retry_cnt", 32'(retry_cnt), m_retry);
      chk("last_lat", 32'(last_lat), m_lat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int hi;
    bit saw_done;
    int ack_div;

    // 1: reset and basic success
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_lat", 32'(last_lat), 0);
    run_start();
    chk("t1_req_up", {31'd0, req}, 1);
    ticks(3);
    ack = 1'b1;
    tick();
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_lat", 32'(last_lat), 3);
    chk("t1_req_down", {31'd0, req}, 0);
    ack = 1'b0;
    tick();
    chk("t1_done_clr", {31'd0, done}, 0);
    chk("t1_busy", {31'd0, busy}, 0);

    // 2: one retry, success 5 cycles into attempt 2
    run_start();
    ticks(T);
    chk("t2_gap_req", {31'd0, req}, 0);
    chk("t2_retry1", 32'(retry_cnt), 1);
    ticks(G);
    chk("t2_req_again", {31'd0, req}, 1);
    ticks(4);
    ack = 1'b1;
    tick();
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_lat", 32'(last_lat), 4);
    chk("t2_retry", 32'(retry_cnt), 1);
    ack = 1'b0;
    tick();

    // 3: exhaustion
    run_start();
    hi = int'(req);
    saw_done = 0;
    for (int i = 0; i < (MR + 1) * T + MR * G - 1; i++) begin
      tick();
      hi += int'(req);
      if (done) saw_done = 1;
    end
    chk("t3_req_cycles", hi, (MR + 1) * T);
    tick();
    chk("t3_err", {31'd0, err}, 1);
    chk("t3_retry", 32'(retry_cnt), MR);
    chk("t3_no_done", {31'd0, saw_done}, 0);
    tick();
    chk("t3_err_clr", {31'd0, err}, 0);
    chk("t3_idle", {31'd0, busy}, 0);

    // 4: stale ack
    ack = 1'b1;
    tick();
    run_start();
    ticks(5);
    chk("t4_no_done", {31'd0, done}, 0);
    chk("t4_busy", {31'd0, busy}, 1);
    ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_lat", 32'(last_lat), 6);
    ack = 1'b0;
    tick();

    // 5a: ack rise on the last attempt cycle wins over timeout
    run_start();
    ticks(T - 1);
    ack = 1'b1;
    tick();
    chk("t5_edge_done", {31'd0, done}, 1);
    chk("t5_edge_retry", 32'(retry_cnt), 0);
    chk("t5_edge_lat", 32'(last_lat), T - 1);
    ack = 1'b0;
    tick();
    // 5b: abort beats ack rise
    run_start();
    ticks(3);
    ack = 1'b1;
    abort = 1'b1;
    tick();
    chk("t5_abort_done", {31'd0, done}, 0);
    chk("t5_abort_busy", {31'd0, busy}, 0);
    abort = 1'b0;
    ack = 1'b0;
    tick();
    chk("t5_abort_lat", 32'(last_lat), T - 1);
    // 5c: start while busy is ignored
    run_start();
    ticks(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    ack = 1'b1;
    tick();
    chk("t5_busy_start_lat", 32'(last_lat), 3);
    ack = 1'b0;
    tick();

    // 6: reset during the gap after the second timeout
    run_start();
    ticks(2 * T + G);
    chk("t6_retry2", 32'(retry_cnt), 2);
    chk("t6_gap_req", {31'd0, req}, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_req", {31'd0, req}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_retry", 32'(retry_cnt), 0);
    chk("t6_lat", 32'(last_lat), 0);
    run_start();
    ticks(2);
    ack = 1'b1;
    tick();
    chk("t6_done", {31'd0, done}, 1);
    chk("t6_new_lat", 32'(last_lat), 2);
    ack = 1'b0;
    tick();

    // Random traffic, alternating fast and slow responders
    for (int i = 0; i < 4000; i++) begin
      ack_div = ((i / 500) % 2 == 1) ? 40 : 6;
      rst   = ($urandom_range(0, 599) == 0);
      abort = ($urandom_range(0, 89) == 0);
      start = !abort && ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, ack_div - 1) == 0) ack = ~ack;
      tick();
    end
    rst = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
